unidade_salto: RTL and testbench

Registered branch-resolution unit for the processor control path, successor to the combinational branch-condition comparator. Holds the status-flag register, evaluates a branch condition against it with selectable polarity, and delivers a registered taken/not-taken decision one cycle later. A taken branch starts a fixed-length pipeline flush, during which the unit reports busy and drops new requests. Flag count, condition-code width and flush length are parameters.

---
 rtl/unidade_salto.sv | 115 +++++++++++
 tb/tb_unidade_salto.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/unidade_salto.sv
// Registered branch-resolution unit: flag register, condition decode, 1-cycle decision, flush timer.
// Optional UNIDADE_SALTO_BYPASS_EN: evaluate against flags_in when flags_we is high in the same cycle.
module unidade_salto #(
    parameter int N_FLAGS      = 6,
    parameter int COND_W       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_FLAGS-1:0] flags_in,
    input  logic               flags_we,
    input  logic               avaliar,
    input  logic [COND_W-1:0]  condicao,
    input  logic               control,
    output logic               salto,
    output logic               resolvido,
    output logic               invalido,
    output logic               descarte,
    output logic               ocupado,
    output logic [N_FLAGS-1:0] flags_q
);

    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [N_FLAGS-1:0] flags_eval;
    logic               r;
    logic               cond_ok;
    logic               d;
    logic               aceita;

`ifdef UNIDADE_SALTO_BYPASS_EN
    assign flags_eval = flags_we ? flags_in : flags_q;
`else
    assign flags_eval = flags_q;
`endif

    // Code 0 selects a constant 1, so polarity alone picks "always" or "never".
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
        r       = 1'b0;
        cond_ok = 1'b0;
        if (condicao == '0) begin
            r       = 1'b1;
            cond_ok = 1'b1;
        end else begin
            for (int k = 1; k <= N_FLAGS; k++) begin
                if (condicao == COND_W'(k)) begin
                    r       = flags_eval[k-1];
                    cond_ok = 1'b1;
                end
            end
        end
    end

    assign d      = cond_ok && (control == r);
    assign aceita = avaliar && (state == IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (aceita && d && (FLUSH_CYCLES > 0)) begin
                    state_nx = FLUSH;
                    cnt_nx   = CNT_W'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                // Leaving at count 1 (or below, defensively) keeps the counter from wrapping.
                if (cnt <= CNT_W'(1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            flags_q   <= '0;
            resolvido <= 1'b0;
            salto     <= 1'b0;
            invalido  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            if (flags_we) begin
                flags_q <= flags_in;
            end
            resolvido <= aceita;
            salto     <= aceita && d;
            invalido  <= aceita && !cond_ok;
        end
    end

    assign ocupado  = (state == FLUSH);
    assign descarte = ocupado;

endmodule

// File: tb/tb_unidade_salto.sv
// Scoreboarded bench for unidade_salto: directed scenarios followed by random traffic.
// Expectations come from a cycle-level model kept here; a negedge monitor compares.
module tb_unidade_salto;

    localparam int N  = 6;
    localparam int CW = 4;
    localparam int FC = 2;
`ifdef UNIDADE_SALTO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  flags_in;
    logic          flags_we;
    logic          avaliar;
    logic [CW-1:0] condicao;
    logic          control;
    logic          salto, resolvido, invalido, descarte, ocupado;
    logic [N-1:0]  flags_q;

    unidade_salto #(.N_FLAGS(N), .COND_W(CW), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .flags_in(flags_in), .flags_we(flags_we),
        .avaliar(avaliar), .condicao(condicao), .control(control),
        .salto(salto), .resolvido(resolvido), .invalido(invalido),
        .descarte(descarte), .ocupado(ocupado), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stamp;
        bit d;
        bit inv;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           busy_m = 0;
    logic [N-1:0] flags_m = '0;
    bit           mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model of one rising edge, using the inputs that were held across it.
    task automatic model_edge();
        logic [N-1:0] f;
        int  c;
        bit  acc, rr, dd, inv;
        cyc++;
        if (reset) begin
            flags_m = '0;
            busy_m  = 0;
        end else begin
            acc = avaliar && (busy_m == 0);
            if (busy_m > 0) busy_m--;
            if (acc) begin
                f   = (BYP && flags_we) ? flags_in : flags_m;
                c   = int'(condicao);
                inv = 1'b0;
                rr  = 1'b0;
                if (c == 0)      rr = 1'b1;
                else if (c <= N) rr = f[c-1];
                else             inv = 1'b1;
                dd = !inv && (rr == control);
                sb.push_back('{stamp: cyc, d: dd, inv: inv});
                if (dd && FC > 0) busy_m = FC;
            end
            if (flags_we) flags_m = flags_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit rst, input bit we, input logic [N-1:0] fi,
                         input bit av, input int cond, input bit ctl);
        reset    = rst;
        flags_we = we;
        flags_in = fi;
        avaliar  = av;
        condicao = CW'(cond);
        control  = ctl;
    endtask

    task automatic idle(input int n);
        drive(0, 0, '0, 0, 0, 0);
        repeat (n) tick();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("ocupado", 32'(ocupado), 32'(busy_m > 0));
            check("descarte", 32'(descarte), 32'(busy_m > 0));
            check("flags_q", 32'(flags_q), 32'(flags_m));
            while (sb.size() > 0 && sb[0].stamp < cyc) begin
                check("missed_resolvido", 32'(sb[0].stamp), 32'(cyc));
                void'(sb.pop_front());
            end
            if (resolvido === 1'b1) begin
                if (sb.size() == 0 || sb[0].stamp != cyc) begin
                    check("unexpected_resolvido", 32'(resolvido), 32'h0);
                end else begin
                    check("salto", 32'(salto), 32'(sb[0].d));
                    check("invalido", 32'(invalido), 32'(sb[0].inv));
                    void'(sb.pop_front());
                end
            end else begin
                check("resolvido", 32'(resolvido), 32'(sb.size() > 0 && sb[0].stamp == cyc));
                check("salto_idle", 32'(salto), 32'h0);
                check("invalido_idle", 32'(invalido), 32'h0);
            end
        end
    end

    initial begin
        drive(1, 0, '0, 0, 0, 0);
        tick();
        tick();
        check("rst_salto", 32'(salto), 32'h0);
        check("rst_resolvido", 32'(resolvido), 32'h0);
        check("rst_invalido", 32'(invalido), 32'h0);
        check("rst_descarte", 32'(descarte), 32'h0);
        check("rst_ocupado", 32'(ocupado), 32'h0);
        check("rst_flags_q", 32'(flags_q), 32'h0);
        mon_en = 1'b1;

        // Taken branch on flag 2, then the flush window.
        drive(0, 1, 6'b000100, 0, 0, 0); tick();
        drive(0, 0, '0, 1, 3, 1);         tick();
        idle(3);
        // Not-taken followed back-to-back by a taken-on-clear.
        drive(0, 0, '0, 1, 3, 0); tick();
        drive(0, 0, '0, 1, 1, 0); tick();
        idle(3);

        // Full code sweep against 101010, both polarities.
        drive(0, 1, 6'b101010, 0, 0, 0); tick();
        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < 2; p++) begin
                drive(0, 0, '0, 1, c, p[0]); tick();
                idle(FC + 1);
            end
        end

        // Request held through the flush: only the first post-flush cycle accepts it.
        drive(0, 0, '0, 1, 0, 1); tick();
        drive(0, 0, '0, 1, 0, 0); repeat (FC + 1) tick();
        idle(2);

        // Write and evaluate in the same cycle, old flags 0.
        drive(1, 0, '0, 0, 0, 0);        tick();
        drive(0, 1, 6'b000001, 1, 1, 1); tick();
        idle(3);

        // Reset during the first flush cycle, request discarded with it, then a fresh request.
        drive(0, 1, 6'b111111, 1, 0, 1); tick();
        drive(1, 1, 6'b010101, 1, 2, 1); tick();
        drive(0, 0, '0, 1, 1, 0);         tick();
        idle(3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 3), N'($urandom),
                  ($urandom_range(0, 9) < 6), int'($urandom_range(0, 15)), 1'($urandom));
            tick();
        end
        idle(FC + 3);

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
